fma16_flag_writeback: RTL and testbench

Output stage of the fp16 FMA unit. Accepts one finished operation per handshake (final 16-bit result plus exception indications from the special-case logic and rounder), masks flags that IEEE 754 forbids on exact special results, and buffers results in a small FIFO toward the consumer. Accumulates sticky IEEE exception flags for software to read and clear.

---
 rtl/fma16_pkg.sv | 35 +++
 rtl/fma16_flag_writeback_if.sv | 48 ++++
 rtl/fma16_flag_fifo.sv | 65 ++++++
 rtl/fma16_flag_writeback.sv | 77 +++++++
 tb/tb_fma16_flag_writeback.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fma16_pkg.sv
// Shared fp16 FMA types: exception flag struct, flag bit positions and the canonical quiet NaN.
// The flag masking rule lives here so the special-case logic and the writeback stage agree on it.
package fma16_pkg;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fma16_flags_t;

    localparam int FLAG_NV = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [15:0] QNAN16 = 16'h7E00;

    // Exact special results and invalid operations may only ever raise invalid.
    function automatic fma16_flags_t mask_flags(
        input logic invalid,
        input logic overflow,
        input logic underflow,
        input logic inexact,
        input logic special_case
    );
        fma16_flags_t f;
        f.invalid   = invalid;
        f.overflow  = overflow  & ~invalid & ~special_case;
        f.underflow = underflow & ~invalid & ~special_case;
        f.inexact   = inexact   & ~invalid & ~special_case;
        return f;
    endfunction

endpackage

// File: rtl/fma16_flag_writeback_if.sv
// Producer/consumer/flag bus of the fp16 FMA writeback stage.
// Counter signals exist only when FMA16_FLAG_COUNT_EN is defined.
interface fma16_flag_writeback_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [15:0]   result;
    logic          invalid;
    logic          overflow;
    logic          underflow;
    logic          inexact;
    logic          special_case;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_result;
    logic [3:0]    out_flags;
    logic [3:0]    sticky_flags;
    logic          clear_flags;
    logic [CW-1:0] count;
`ifdef FMA16_FLAG_COUNT_EN
    logic [7:0]    cnt_invalid;
    logic [7:0]    cnt_overflow;
    logic [7:0]    cnt_underflow;
    logic [7:0]    cnt_inexact;
`endif

    modport master (
        output in_valid, result, invalid, overflow, underflow, inexact, special_case,
        output out_ready, clear_flags,
        input  in_ready, out_valid, out_result, out_flags, sticky_flags, count
`ifdef FMA16_FLAG_COUNT_EN
        , input cnt_invalid, cnt_overflow, cnt_underflow, cnt_inexact
`endif
    );

    modport slave (
        input  in_valid, result, invalid, overflow, underflow, inexact, special_case,
        input  out_ready, clear_flags,
        output in_ready, out_valid, out_result, out_flags, sticky_flags, count
`ifdef FMA16_FLAG_COUNT_EN
        , output cnt_invalid, cnt_overflow, cnt_underflow, cnt_inexact
`endif
    );

endinterface

// File: rtl/fma16_flag_fifo.sv
// Registered FIFO for result+flag entries; ready/valid derive from the occupancy count only.
// A full FIFO refuses pushes even when a pop happens in the same cycle.
module fma16_flag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_req,
    input  logic                       pop_req,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q < FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push      = push_req & in_ready;
    assign pop       = pop_req & out_valid;
    assign count     = count_q;
    assign rd_data   = out_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are hidden by the zero-when-empty read mux.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/fma16_flag_writeback.sv
// fp16 FMA output stage: masks flags, buffers results, accumulates sticky IEEE flags.
// Define FMA16_FLAG_COUNT_EN to add saturating 8-bit per-flag event counters.
module fma16_flag_writeback
    import fma16_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    fma16_flag_writeback_if.slave       bus
);
    fma16_flags_t masked;
    logic [3:0]   masked_vec;
    logic [19:0]  rd_data;
    logic         push;
    logic [3:0]   sticky_q, sticky_d;

    assign masked     = mask_flags(bus.invalid, bus.overflow, bus.underflow,
                                   bus.inexact, bus.special_case);
    assign masked_vec = masked;
    assign push       = bus.in_valid & bus.in_ready;

    fma16_flag_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (20)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push_req  (bus.in_valid),
        .pop_req   (bus.out_ready),
        .wr_data   ({bus.result, masked_vec}),
        .in_ready  (bus.in_ready),
        .out_valid (bus.out_valid),
        .rd_data   (rd_data),
        .count     (bus.count)
    );

    assign bus.out_result   = rd_data[19:4];
    assign bus.out_flags    = rd_data[3:0];
    assign bus.sticky_flags = sticky_q;

    // Clear takes effect before the same-cycle push is merged in.
    always_comb begin
        sticky_d = bus.clear_flags ? 4'b0000 : sticky_q;
        if (push) sticky_d = sticky_d | masked_vec;
    end

    always_ff @(posedge clk) begin
        if (reset) sticky_q <= 4'b0000;
        else       sticky_q <= sticky_d;
    end

`ifdef FMA16_FLAG_COUNT_EN
    logic [7:0] cnt_q [4];
    logic [7:0] cnt_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = bus.clear_flags ? 8'd0 : cnt_q[i];
            if (push && masked_vec[i] && cnt_d[i] != 8'hFF) cnt_d[i] = cnt_d[i] + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) cnt_q[i] <= 8'd0;
            else       cnt_q[i] <= cnt_d[i];
        end
    end

    assign bus.cnt_invalid   = cnt_q[FLAG_NV];
    assign bus.cnt_overflow  = cnt_q[FLAG_OF];
    assign bus.cnt_underflow = cnt_q[FLAG_UF];
    assign bus.cnt_inexact   = cnt_q[FLAG_NX];
`endif

endmodule

// File: tb/tb_fma16_flag_writeback.sv
// Directed self-checking bench for fma16_flag_writeback (DEPTH=4).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fma16_flag_writeback;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    fma16_flag_writeback_if #(.DEPTH(4)) bus ();

    fma16_flag_writeback #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid     = 1'b0;
        bus.result       = 16'h0000;
        bus.invalid      = 1'b0;
        bus.overflow     = 1'b0;
        bus.underflow    = 1'b0;
        bus.inexact      = 1'b0;
        bus.special_case = 1'b0;
        bus.clear_flags  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        bus.out_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic set_op(input logic [15:0] r, input logic [3:0] f, input logic sc);
        bus.in_valid     = 1'b1;
        bus.result       = r;
        bus.invalid      = f[3];
        bus.overflow     = f[2];
        bus.underflow    = f[1];
        bus.inexact      = f[0];
        bus.special_case = sc;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.count !== 3'd0) begin
            miscompares++; $display("[TB] FAIL reset_count got %0d want 0", bus.count);
        end
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL reset_handshake got in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        vectors++;
        if (bus.out_result !== 16'h0000 || bus.out_flags !== 4'b0000 || bus.sticky_flags !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL reset_outputs got res=%h flags=%b sticky=%b want 0", bus.out_result, bus.out_flags, bus.sticky_flags);
        end
    endtask

    task automatic test_basic_push();
        do_reset();
        bus.out_ready = 1'b1;
        set_op(16'h3C00, 4'b0001, 1'b0);
        step();
        idle_inputs();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 16'h3C00) begin
            miscompares++; $display("[TB] FAIL basic_head got valid=%b res=%h want 1/3c00", bus.out_valid, bus.out_result);
        end
        vectors++;
        if (bus.out_flags !== 4'b0001 || bus.sticky_flags !== 4'b0001) begin
            miscompares++; $display("[TB] FAIL basic_flags got flags=%b sticky=%b want 0001/0001", bus.out_flags, bus.sticky_flags);
        end
        step();
        vectors++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.sticky_flags !== 4'b0001) begin
            miscompares++; $display("[TB] FAIL basic_pop got count=%0d valid=%b sticky=%b want 0/0/0001", bus.count, bus.out_valid, bus.sticky_flags);
        end
    endtask

    task automatic test_masking();
        do_reset();
        bus.out_ready = 1'b1;
        set_op(16'h7E00, 4'b1101, 1'b1);
        step();
        idle_inputs();
        vectors++;
        if (bus.out_result !== 16'h7E00 || bus.out_flags !== 4'b1000 || bus.sticky_flags !== 4'b1000) begin
            miscompares++; $display("[TB] FAIL mask_special got res=%h flags=%b sticky=%b want 7e00/1000/1000", bus.out_result, bus.out_flags, bus.sticky_flags);
        end
        set_op(16'h4000, 4'b1110, 1'b0);
        step();
        vectors++;
        if (bus.out_flags !== 4'b1000) begin
            miscompares++; $display("[TB] FAIL mask_invalid got flags=%b want 1000", bus.out_flags);
        end
        set_op(16'h7C00, 4'b0111, 1'b0);
        step();
        vectors++;
        if (bus.out_result !== 16'h7C00 || bus.out_flags !== 4'b0111 || bus.sticky_flags !== 4'b1111) begin
            miscompares++; $display("[TB] FAIL mask_normal got res=%h flags=%b sticky=%b want 7c00/0111/1111", bus.out_result, bus.out_flags, bus.sticky_flags);
        end
        set_op(16'h0001, 4'b0110, 1'b1);
        step();
        idle_inputs();
        vectors++;
        if (bus.out_flags !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL mask_special_clean got flags=%b want 0000", bus.out_flags);
        end
    endtask

    task automatic test_full();
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            set_op(16'(i), 4'b0001, 1'b0);
            vectors++;
            if (bus.in_ready !== 1'b1) begin
                miscompares++; $display("[TB] FAIL fill_ready op%0d got %b want 1", i, bus.in_ready);
            end
            step();
        end
        set_op(16'h0005, 4'b0010, 1'b0);
        vectors++;
        if (bus.in_ready !== 1'b0 || bus.count !== 3'd4) begin
            miscompares++; $display("[TB] FAIL full_state got in_ready=%b count=%0d want 0/4", bus.in_ready, bus.count);
        end
        step();
        vectors++;
        if (bus.count !== 3'd4 || bus.out_result !== 16'h0001) begin
            miscompares++; $display("[TB] FAIL full_hold got count=%0d res=%h want 4/0001", bus.count, bus.out_result);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.count !== 3'd3 || bus.out_result !== 16'h0002 || bus.in_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL full_pop_no_pass got count=%0d res=%h in_ready=%b want 3/0002/1", bus.count, bus.out_result, bus.in_ready);
        end
        step();
        idle_inputs();
        vectors++;
        if (bus.count !== 3'd4) begin
            miscompares++; $display("[TB] FAIL full_fifth_accept got count=%0d want 4", bus.count);
        end
        bus.out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 16'(i)) begin
                miscompares++; $display("[TB] FAIL drain_order got valid=%b res=%h want 1/%h", bus.out_valid, bus.out_result, 16'(i));
            end
            step();
        end
        vectors++;
        if (bus.count !== 3'd0 || bus.sticky_flags !== 4'b0011) begin
            miscompares++; $display("[TB] FAIL drain_end got count=%0d sticky=%b want 0/0011", bus.count, bus.sticky_flags);
        end
    endtask

    task automatic test_clear();
        do_reset();
        bus.out_ready = 1'b1;
        set_op(16'h1234, 4'b0101, 1'b0);
        step();
        vectors++;
        if (bus.sticky_flags !== 4'b0101) begin
            miscompares++; $display("[TB] FAIL clear_setup got %b want 0101", bus.sticky_flags);
        end
        set_op(16'h5678, 4'b0100, 1'b0);
        bus.clear_flags = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if (bus.sticky_flags !== 4'b0100) begin
            miscompares++; $display("[TB] FAIL clear_with_push got %b want 0100", bus.sticky_flags);
        end
        step();
        vectors++;
        if (bus.sticky_flags !== 4'b0100 || bus.count !== 3'd0) begin
            miscompares++; $display("[TB] FAIL pop_keeps_sticky got sticky=%b count=%0d want 0100/0", bus.sticky_flags, bus.count);
        end
        bus.clear_flags = 1'b1;
        step();
        bus.clear_flags = 1'b0;
        vectors++;
        if (bus.sticky_flags !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL clear_alone got %b want 0000", bus.sticky_flags);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b1;
        set_op(16'hA000, 4'b0000, 1'b0);
        step();
        for (int i = 1; i <= 3; i++) begin
            set_op(16'hA000 + 16'(i), 4'b0000, 1'b0);
            vectors++;
            if (bus.count !== 3'd1 || bus.out_result !== 16'hA000 + 16'(i - 1)) begin
                miscompares++; $display("[TB] FAIL b2b_stream got count=%0d res=%h want 1/%h", bus.count, bus.out_result, 16'hA000 + 16'(i - 1));
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_op(16'hBEEF, 4'b0011, 1'b0);
            step();
        end
        vectors++;
        if (bus.count !== 3'd3 || bus.sticky_flags !== 4'b0011) begin
            miscompares++; $display("[TB] FAIL midreset_fill got count=%0d sticky=%b want 3/0011", bus.count, bus.sticky_flags);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle_inputs();
        vectors++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++; $display("[TB] FAIL midreset_state got count=%0d valid=%b in_ready=%b want 0/0/1", bus.count, bus.out_valid, bus.in_ready);
        end
        vectors++;
        if (bus.out_result !== 16'h0000 || bus.out_flags !== 4'b0000 || bus.sticky_flags !== 4'b0000) begin
            miscompares++; $display("[TB] FAIL midreset_outputs got res=%h flags=%b sticky=%b want 0", bus.out_result, bus.out_flags, bus.sticky_flags);
        end
    endtask

`ifdef FMA16_FLAG_COUNT_EN
    task automatic test_counters();
        do_reset();
        bus.out_ready = 1'b1;
        set_op(16'h3C01, 4'b0001, 1'b0);
        for (int i = 0; i < 300; i++) step();
        idle_inputs();
        vectors++;
        if (bus.cnt_inexact !== 8'd255 || bus.cnt_invalid !== 8'd0) begin
            miscompares++; $display("[TB] FAIL cnt_saturate got nx=%0d nv=%0d want 255/0", bus.cnt_inexact, bus.cnt_invalid);
        end
        bus.clear_flags = 1'b1;
        step();
        bus.clear_flags = 1'b0;
        vectors++;
        if (bus.cnt_inexact !== 8'd0) begin
            miscompares++; $display("[TB] FAIL cnt_clear got %0d want 0", bus.cnt_inexact);
        end
        set_op(16'h7E00, 4'b1000, 1'b0);
        bus.clear_flags = 1'b1;
        step();
        idle_inputs();
        vectors++;
        if (bus.cnt_invalid !== 8'd1 || bus.cnt_overflow !== 8'd0) begin
            miscompares++; $display("[TB] FAIL cnt_clear_push got nv=%0d of=%0d want 1/0", bus.cnt_invalid, bus.cnt_overflow);
        end
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.out_ready = 1'b0;
        idle_inputs();
        step();
        test_reset();
        test_basic_push();
        test_masking();
        test_full();
        test_clear();
        test_back_to_back();
        test_mid_reset();
`ifdef FMA16_FLAG_COUNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
